match_gap_logger: RTL and testbench

Downstream consumer of the 1010 Mealy sequence detector's single-cycle `dout` pulse. It counts detections, measures the clock-cycle gap between consecutive detections, and buffers gap values in a small FIFO drained over a valid/ready interface. It sits between the detector and any monitoring or CSR logic that reads detection statistics.

---
 rtl/match_logger_pkg.sv | 14 +
 rtl/gap_fifo.sv | 53 +++++
 rtl/match_gap_logger.sv | 84 ++++++++
 tb/tb_match_gap_logger.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/match_logger_pkg.sv
// Shared types and default sizes for the match gap logger.
package match_logger_pkg;

   // IDLE: no detection seen yet; ARMED: a previous detection exists to measure from
   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } logger_state_t;

   localparam int MATCH_CNT_W      = 16;
   localparam int MATCH_GAP_W      = 12;
   localparam int MATCH_FIFO_DEPTH = 4;

endpackage

// File: rtl/gap_fifo.sv
// Show-ahead FIFO for gap values. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits are equal.
module gap_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   // A push while full is only accepted when the head leaves in the same cycle
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is presented directly; empty reads as zero rather than stale storage
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; storage below carries no reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Entry write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/match_gap_logger.sv
// Counts detector pulses, times the gap between consecutive pulses and queues
// the gaps for a valid/ready consumer.
module match_gap_logger
   import match_logger_pkg::*;
#(
   parameter int CNT_W = MATCH_CNT_W,
   parameter int GAP_W = MATCH_GAP_W,
   parameter int DEPTH = MATCH_FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    match_in,
   input  logic                    clear,
   output logic [GAP_W-1:0]        gap_data,
   output logic                    gap_valid,
   input  logic                    gap_ready,
   output logic [CNT_W-1:0]        match_count,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   logger_state_t    state;
   logic [GAP_W-1:0] gt;
   logic             flush;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;

   function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
      return (&v) ? v : v + GAP_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Clear behaves exactly like reset and overrides a same-cycle match
   assign flush     = rst || clear;
   assign push      = (state == ARMED) && match_in && !clear;
   assign gap_valid = !fifo_empty;
   assign pop       = gap_valid && gap_ready;

   // State and gap timer: timer restarts at 1 on each match, saturates between matches
   always_ff @(posedge clk) begin
      if (flush) begin
         state <= IDLE;
         gt    <= '0;
      end else if (match_in) begin
         state <= ARMED;
         gt    <= GAP_W'(1);
      end else if (state == ARMED) begin
         gt    <= gap_sat_inc(gt);
      end
   end

   // Detection counter, saturating
   always_ff @(posedge clk) begin
      if (flush)         match_count <= '0;
      else if (match_in) match_count <= cnt_sat_inc(match_count);
   end

   // Sticky drop flag: a push into a full FIFO with nothing leaving
   always_ff @(posedge clk) begin
      if (flush)                           overflow <= 1'b0;
      else if (push && fifo_full && !pop)  overflow <= 1'b1;
   end

   gap_fifo #(
      .WIDTH (GAP_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (flush),
      .push  (push),
      .pop   (pop),
      .din   (gt),
      .dout  (gap_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

endmodule

// File: tb/tb_match_gap_logger.sv
// Bench for match_gap_logger: cycle-stamped scoreboard of expected gaps plus
// a directed vector table and hand-written corner sequences.
module tb_match_gap_logger;
   import match_logger_pkg::*;

   localparam int GW   = 12;
   localparam int CW   = 16;
   localparam int DP   = 4;
   localparam int GMAX = (1 << GW) - 1;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          match_in;
   logic          clear;
   logic [GW-1:0] gap_data;
   logic          gap_valid;
   logic          gap_ready;
   logic [CW-1:0] match_count;
   logic          overflow;
   logic [2:0]    fifo_level;

   logic          match_s;
   logic          clear_s;
   logic          gap_ready_s;
   logic [GW-1:0] gap_data_s;
   logic          gap_valid_s;
   logic [3:0]    match_count_s;
   logic          overflow_s;
   logic [2:0]    fifo_level_s;

   always #5 clk = ~clk;

   match_gap_logger #(.CNT_W(CW), .GAP_W(GW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .match_in(match_in), .clear(clear),
      .gap_data(gap_data), .gap_valid(gap_valid), .gap_ready(gap_ready),
      .match_count(match_count), .overflow(overflow), .fifo_level(fifo_level)
   );

   match_gap_logger #(.CNT_W(4), .GAP_W(GW), .DEPTH(DP)) dut_s (
      .clk(clk), .rst(rst), .match_in(match_s), .clear(clear_s),
      .gap_data(gap_data_s), .gap_valid(gap_valid_s), .gap_ready(gap_ready_s),
      .match_count(match_count_s), .overflow(overflow_s), .fifo_level(fifo_level_s)
   );

   int total = 0;
   int bad   = 0;

   // scoreboard model
   int q[$];
   bit armed = 0;
   int last  = 0;
   int cyc   = 0;
   int ecnt  = 0;
   bit eovf  = 0;

   typedef struct {
      bit m;
      bit rdy;
      bit clr;
      bit v;
      int d;
      int c;
      int l;
   } vec_t;

   vec_t tbl[9];

   function automatic void chk(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Drive one cycle of inputs, check head before the edge, update model, check after.
   task automatic step(input bit m, input bit rdy, input bit clr);
      int g;
      int hd;
      match_in  = m;
      gap_ready = rdy;
      clear     = clr;
      hd = (q.size() != 0) ? q[0] : 0;
      chk("head_valid", gap_valid, q.size() != 0);
      chk("head_data", gap_data, hd);
      if (clr) begin
         q.delete();
         armed = 0;
         ecnt  = 0;
         eovf  = 0;
      end else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (m) begin
            if (armed) begin
               g = cyc - last;
               if (g > GMAX) g = GMAX;
               if (q.size() < DP) q.push_back(g);
               else eovf = 1;
            end
            armed = 1;
            last  = cyc;
            if (ecnt < CMAX) ecnt++;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("match_count", match_count, ecnt);
      chk("overflow", overflow, eovf);
      chk("fifo_level", fifo_level, q.size());
   endtask

   initial begin
      rst = 1; match_in = 0; clear = 0; gap_ready = 0;
      match_s = 0; clear_s = 0; gap_ready_s = 1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", gap_valid, 0);
      chk("rst_data", gap_data, 0);
      chk("rst_count", match_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_count_small", match_count_s, 0);
      rst = 0;
      cyc = 0;

      // directed table: expected outputs after the clock edge
      tbl[0] = '{1, 0, 0, 0, 0, 1, 0};
      tbl[1] = '{0, 0, 0, 0, 0, 1, 0};
      tbl[2] = '{1, 0, 0, 1, 2, 2, 1};
      tbl[3] = '{1, 0, 0, 1, 2, 3, 2};
      tbl[4] = '{1, 0, 1, 0, 0, 0, 0};
      tbl[5] = '{1, 0, 0, 0, 0, 1, 0};
      tbl[6] = '{0, 1, 0, 0, 0, 1, 0};
      tbl[7] = '{1, 1, 0, 1, 2, 2, 1};
      tbl[8] = '{0, 1, 0, 0, 0, 2, 0};
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].m, tbl[i].rdy, tbl[i].clr);
         chk("tbl_valid", gap_valid, tbl[i].v);
         chk("tbl_data", gap_data, tbl[i].d);
         chk("tbl_count", match_count, tbl[i].c);
         chk("tbl_level", fifo_level, tbl[i].l);
      end

      // matches at 10, 20, 23 with ready held high
      step(0, 1, 1);
      for (int k = 0; k < 30; k++) begin
         step((k == 10) || (k == 20) || (k == 23), 1, 0);
         if (k == 20) begin
            chk("t1_gap10_valid", gap_valid, 1);
            chk("t1_gap10_data", gap_data, 10);
         end
         if (k == 21) chk("t1_pulse_end", gap_valid, 0);
         if (k == 23) chk("t1_gap3_data", gap_data, 3);
      end
      chk("t1_count", match_count, 3);

      // long gap saturates
      step(0, 1, 1);
      step(1, 1, 0);
      repeat (4999) step(0, 1, 0);
      step(1, 1, 0);
      chk("t2_sat_valid", gap_valid, 1);
      chk("t2_sat_data", gap_data, GMAX);
      chk("t2_overflow", overflow, 0);
      step(0, 1, 0);

      // fill with ready low, overflow on fifth gap, then drain
      step(0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0);
         repeat (3) step(0, 0, 0);
      end
      chk("t3_level", fifo_level, 4);
      chk("t3_overflow", overflow, 1);
      chk("t3_count", match_count, 6);
      for (int i = 0; i < 4; i++) begin
         chk("t3_drain_data", gap_data, 4);
         step(0, 1, 0);
      end
      chk("t3_drained", gap_valid, 0);
      chk("t3_ovf_sticky", overflow, 1);

      // full FIFO, push and pop in the same cycle
      step(0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0);
         step(0, 0, 0);
      end
      chk("t4_full", fifo_level, 4);
      step(0, 0, 0);
      step(1, 1, 0);
      chk("t4_level", fifo_level, 4);
      chk("t4_overflow", overflow, 0);
      repeat (3) step(0, 1, 0);
      chk("t4_tail", gap_data, 3);
      step(0, 1, 0);
      chk("t4_empty", gap_valid, 0);

      // narrow counter saturation on the second instance
      for (int i = 0; i < 17; i++) begin
         match_s = 1;
         step(0, 1, 0);
         if (i == 13) chk("t5_count14", match_count_s, 14);
      end
      match_s = 0;
      step(0, 1, 0);
      chk("t5_count_sat", match_count_s, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
